// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the multiplier operand sequencer.
// Holds the FSM encoding, default sizes and the address-range check.
package mul_seq_pkg;

    localparam int DEFAULT_DEPTH   = 48;
    localparam int DEFAULT_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CAPT  = 3'd2,
        S_START = 3'd3,
        S_WAIT  = 3'd4,
        S_WRITE = 3'd5,
        S_DONE  = 3'd6
    } state_e;

    function automatic logic addr_ok(input int addr, input int depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/mul_operand_sequencer_if.sv
// Command, RAM and multiplier bundle of the operand sequencer.
// master is the sequencer side, slave the RAM/multiplier/host side.
interface mul_operand_sequencer_if #(
    parameter int DATA = 256,
    parameter int ADDR = 6
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [ADDR-1:0] cmd_src_a;
    logic [ADDR-1:0] cmd_src_b;
    logic [ADDR-1:0] cmd_dst;
    logic            a_w;
    logic [ADDR-1:0] a_adbus;
    logic [DATA-1:0] a_data_in;
    logic [DATA-1:0] a_data_out;
    logic            b_w;
    logic [ADDR-1:0] b_adbus;
    logic [DATA-1:0] b_data_in;
    logic [DATA-1:0] b_data_out;
    logic            mul_start;
    logic [DATA-1:0] mul_op_a;
    logic [DATA-1:0] mul_op_b;
    logic            mul_done;
    logic [DATA-1:0] mul_result;
    logic            done;
    logic            err;
    logic            busy;

    modport master (
        input  cmd_valid, cmd_src_a, cmd_src_b, cmd_dst,
        input  a_data_out, b_data_out, mul_done, mul_result,
        output cmd_ready, a_w, a_adbus, a_data_in,
        output b_w, b_adbus, b_data_in,
        output mul_start, mul_op_a, mul_op_b,
        output done, err, busy
    );

    modport slave (
        output cmd_valid, cmd_src_a, cmd_src_b, cmd_dst,
        output a_data_out, b_data_out, mul_done, mul_result,
        input  cmd_ready, a_w, a_adbus, a_data_in,
        input  b_w, b_adbus, b_data_in,
        input  mul_start, mul_op_a, mul_op_b,
        input  done, err, busy
    );
endinterface

// File: rtl/mul_seq_timeout_ctr.sv
// Clear/enable cycle counter with a terminal flag.
// last is high when the next enabled count reaches LIMIT.
module mul_seq_timeout_ctr #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // clear has priority over increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/mul_operand_sequencer.sv
// Reads two RAM operands, runs the field multiplier, writes back.
// One command in flight; outputs decode from registered state/data.
module mul_operand_sequencer
    import mul_seq_pkg::*;
#(
    parameter int DATA    = 256,
    parameter int ADDR    = 6,
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input logic                   clk,
    input logic                   rst_n,
    mul_operand_sequencer_if.master bus
);
    state_e          state_q, state_d;
    logic [ADDR-1:0] a_ad_q, a_ad_d;
    logic [ADDR-1:0] b_ad_q, b_ad_d;
    logic [ADDR-1:0] dst_q, dst_d;
    logic [DATA-1:0] op_a_q, op_a_d;
    logic [DATA-1:0] op_b_q, op_b_d;
    logic [DATA-1:0] res_q, res_d;
    logic            err_q, err_d;
    logic            ctr_clr;
    logic            ctr_en;
    logic            ctr_last;
    logic            cmd_ok;

    assign cmd_ok = addr_ok(int'(bus.cmd_src_a), DEPTH)
                 && addr_ok(int'(bus.cmd_src_b), DEPTH)
                 && addr_ok(int'(bus.cmd_dst), DEPTH);

    mul_seq_timeout_ctr #(
        .LIMIT (TIMEOUT)
    ) u_tmo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ctr_clr),
        .en    (ctr_en),
        .last  (ctr_last)
    );

    // next-state and datapath load decisions
    always_comb begin
        state_d = state_q;
        a_ad_d  = a_ad_q;
        b_ad_d  = b_ad_q;
        dst_d   = dst_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_d   = res_q;
        err_d   = 1'b0;
        ctr_clr = 1'b0;
        ctr_en  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    if (cmd_ok) begin
                        a_ad_d  = bus.cmd_src_a;
                        b_ad_d  = bus.cmd_src_b;
                        dst_d   = bus.cmd_dst;
                        state_d = S_READ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                state_d = S_CAPT;
            end
            S_CAPT: begin
                op_a_d  = bus.a_data_out;
                op_b_d  = bus.b_data_out;
                state_d = S_START;
            end
            S_START: begin
                ctr_clr = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.mul_done) begin
                    res_d   = bus.mul_result;
                    a_ad_d  = dst_q;
                    state_d = S_WRITE;
                end else begin
                    ctr_en = 1'b1;
                    if (ctr_last) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WRITE: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // state and datapath registers, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_ad_q  <= '0;
            b_ad_q  <= '0;
            dst_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_ad_q  <= a_ad_d;
            b_ad_q  <= b_ad_d;
            dst_q   <= dst_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign bus.cmd_ready = rst_n && (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.a_w       = (state_q == S_WRITE);
    assign bus.a_adbus   = a_ad_q;
    assign bus.a_data_in = (state_q == S_WRITE) ? res_q : '0;
    assign bus.b_w       = 1'b0;
    assign bus.b_adbus   = b_ad_q;
    assign bus.b_data_in = '0;
    assign bus.mul_start = (state_q == S_START);
    assign bus.mul_op_a  = op_a_q;
    assign bus.mul_op_b  = op_b_q;
    assign bus.done      = (state_q == S_DONE);
    assign bus.err       = err_q;

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Randomized bench for mul_operand_sequencer with RAM, multiplier
// and a cycle-schedule reference model.
module tb_mul_operand_sequencer;
    localparam int DEPTH   = 48;
    localparam int TIMEOUT = 1024;
    localparam logic [255:0] P = (256'd1 << 255) - 256'd19;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    mul_operand_sequencer_if #(.DATA(256), .ADDR(6)) mif ();

    mul_operand_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mif)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] mulmod(input logic [255:0] x, input logic [255:0] y);
        logic [511:0] t;
        t = {256'b0, x} * {256'b0, y};
        t = t % {256'b0, P};
        return t[255:0];
    endfunction

    function automatic void chk1(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0b exp=%0b", nm, cyc, act, exp);
        end
    endfunction

    function automatic void chki(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, act, exp);
        end
    endfunction

    function automatic void chkw(input string nm, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endfunction

    // RAM: registered read-first, port A writes
    logic [255:0] ram [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = {8{$urandom}};
        ram[3] = 256'd5;
        ram[7] = 256'd9;
        ram[1] = 256'd3;
        ram[2] = 256'd4;
        mif.a_data_out = '0;
        mif.b_data_out = '0;
        forever begin
            @(posedge clk);
            mif.a_data_out <= (int'(mif.a_adbus) < DEPTH) ? ram[mif.a_adbus] : '0;
            mif.b_data_out <= (int'(mif.b_adbus) < DEPTH) ? ram[mif.b_adbus] : '0;
            if (mif.a_w && int'(mif.a_adbus) < DEPTH) ram[mif.a_adbus] = mif.a_data_in;
        end
    end

    // multiplier: fixed latency per command, optional spurious pulse
    int  mul_lat = 1;
    bit  mul_never = 1'b0;
    int  spur_at = -1;
    initial begin
        bit           pend;
        int           due;
        logic [255:0] pres;
        pend = 1'b0;
        due = 0;
        pres = '0;
        mif.mul_done = 1'b0;
        mif.mul_result = '0;
        forever begin
            @(negedge clk);
            if (mif.mul_start && !mul_never) begin
                pend = 1'b1;
                due = cyc + mul_lat;
                pres = mulmod(mif.mul_op_a, mif.mul_op_b);
            end
            @(posedge clk);
            #1;
            mif.mul_done = 1'b0;
            if (pend && cyc == due) begin
                mif.mul_done = 1'b1;
                mif.mul_result = pres;
                pend = 1'b0;
            end else if (cyc == spur_at) begin
                mif.mul_done = 1'b1;
                mif.mul_result = {8{$urandom}};
            end
        end
    end

    // reference model: event cycles derived from the command timeline
    logic [255:0] ref_mem [DEPTH];
    int start_c = -1, write_c = -1, done_c = -1, err_c = -1;
    int busy_lo = 1, busy_hi = 0;
    bit wait_open = 1'b0;
    logic [5:0] cur_a = '0, cur_b = '0, dst_m = '0;
    logic [255:0] opa_m = '0, opb_m = '0, prod_m = '0;
    int last_start = -1, last_aw = -1, last_done = -1, last_err = -1;
    int n_aw = 0, n_done = 0, n_err = 0;

    initial begin
        bit e_busy, e_ready, e_w, legal;
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = ram[i];
        forever begin
            @(negedge clk);
            e_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
            e_ready = rst_n && !e_busy;
            e_w = (cyc == write_c);
            chk1("cmd_ready", mif.cmd_ready, e_ready);
            chk1("busy", mif.busy, e_busy);
            chk1("mul_start", mif.mul_start, cyc == start_c);
            chk1("a_w", mif.a_w, e_w);
            chk1("done", mif.done, cyc == done_c);
            chk1("err", mif.err, cyc == err_c);
            chk1("b_w", mif.b_w, 1'b0);
            chki("a_adbus", int'(mif.a_adbus), int'(cur_a));
            chki("b_adbus", int'(mif.b_adbus), int'(cur_b));
            chkw("a_data_in", mif.a_data_in, e_w ? prod_m : '0);
            chkw("b_data_in", mif.b_data_in, '0);
            if (cyc == start_c || (wait_open && cyc > start_c)) begin
                chkw("mul_op_a", mif.mul_op_a, opa_m);
                chkw("mul_op_b", mif.mul_op_b, opb_m);
            end
            if (mif.mul_start) last_start = cyc;
            if (mif.a_w) begin last_aw = cyc; n_aw++; end
            if (mif.done) begin last_done = cyc; n_done++; end
            if (mif.err) begin last_err = cyc; n_err++; end
            if (e_w) ref_mem[dst_m] = prod_m;
            if (wait_open && cyc > start_c) begin
                if (mif.mul_done) begin
                    write_c = cyc + 1;
                    done_c = cyc + 2;
                    busy_hi = cyc + 2;
                    cur_a = dst_m;
                    wait_open = 1'b0;
                end else if (cyc == start_c + TIMEOUT) begin
                    err_c = cyc + 1;
                    busy_hi = cyc;
                    wait_open = 1'b0;
                end
            end
            if (mif.cmd_valid && e_ready) begin
                legal = int'(mif.cmd_src_a) < DEPTH && int'(mif.cmd_src_b) < DEPTH
                     && int'(mif.cmd_dst) < DEPTH;
                if (!legal) begin
                    err_c = cyc + 1;
                end else begin
                    start_c = cyc + 3;
                    busy_lo = cyc + 1;
                    busy_hi = 32'h7fff_ffff;
                    wait_open = 1'b1;
                    cur_a = mif.cmd_src_a;
                    cur_b = mif.cmd_src_b;
                    dst_m = mif.cmd_dst;
                    opa_m = ref_mem[mif.cmd_src_a];
                    opb_m = ref_mem[mif.cmd_src_b];
                    prod_m = mulmod(opa_m, opb_m);
                end
            end
            if (!rst_n) begin
                start_c = -1; write_c = -1; done_c = -1; err_c = -1;
                busy_lo = 1; busy_hi = 0;
                wait_open = 1'b0;
                cur_a = '0; cur_b = '0;
            end
        end
    end

    int acc_cyc = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc();
        int n = 0;
        @(negedge clk);
        while (!mif.cmd_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!mif.cmd_ready) begin
            tests++; fails++;
            $display("FAIL accept_timeout cyc=%0d got=no_ready exp=ready", cyc);
        end
        acc_cyc = cyc;
    endtask

    task automatic send(input int a, input int b, input int d, input int lat, input bit spur);
        mif.cmd_src_a = 6'(a);
        mif.cmd_src_b = 6'(b);
        mif.cmd_dst = 6'(d);
        mul_lat = lat;
        mif.cmd_valid = 1'b1;
        wait_acc();
        if (spur) spur_at = acc_cyc + 2;
        step();
        mif.cmd_valid = 1'b0;
    endtask

    task automatic wait_quiet();
        int n = 0;
        @(negedge clk);
        while (!mif.cmd_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!mif.cmd_ready) begin
            tests++; fails++;
            $display("FAIL idle_timeout cyc=%0d got=busy exp=idle", cyc);
        end
        step();
    endtask

    function automatic int rand_addr();
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(48, 63));
        return int'($urandom_range(0, 47));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int sd, se, saw;
        mif.cmd_valid = 1'b0;
        mif.cmd_src_a = '0;
        mif.cmd_src_b = '0;
        mif.cmd_dst = '0;
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        @(negedge clk);
        chk1("reset_ready", mif.cmd_ready, 1'b1);
        chk1("reset_busy", mif.busy, 1'b0);
        step();

        send(3, 7, 10, 20, 1'b0);
        wait_quiet();
        chki("basic_start_lat", last_start - acc_cyc, 3);
        chki("basic_aw_lat", last_aw - acc_cyc, 24);
        chki("basic_done_lat", last_done - last_aw, 1);
        chkw("basic_ram10", ram[10], 256'd45);
        chkw("basic_model10", ref_mem[10], 256'd45);

        mul_lat = 3;
        mif.cmd_src_a = 6'd1;
        mif.cmd_src_b = 6'd2;
        mif.cmd_dst = 6'd5;
        mif.cmd_valid = 1'b1;
        wait_acc();
        step();
        mif.cmd_src_a = 6'd5;
        mif.cmd_src_b = 6'd5;
        mif.cmd_dst = 6'd6;
        wait_acc();
        chki("b2b_gap", acc_cyc - last_done, 1);
        step();
        mif.cmd_valid = 1'b0;
        wait_quiet();
        chkw("b2b_ram5", ram[5], 256'd12);
        chkw("b2b_ram6", ram[6], 256'd144);

        saw = n_aw;
        send(3, 48, 10, 5, 1'b0);
        wait_quiet();
        chki("illegal_err_lat", last_err - acc_cyc, 1);
        chki("illegal_no_write", n_aw, saw);

        mul_never = 1'b1;
        saw = n_aw;
        send(0, 1, 2, 5, 1'b0);
        wait_quiet();
        chki("timeout_err_lat", last_err - last_start, TIMEOUT + 1);
        chki("timeout_no_write", n_aw, saw);
        mul_never = 1'b0;

        sd = n_done;
        se = n_err;
        send(4, 5, 11, 40, 1'b0);
        repeat (7) step();
        rst_n = 1'b0;
        step();
        @(negedge clk);
        chk1("rst_ready", mif.cmd_ready, 1'b0);
        chk1("rst_busy", mif.busy, 1'b0);
        chk1("rst_start", mif.mul_start, 1'b0);
        chk1("rst_aw", mif.a_w, 1'b0);
        chki("rst_a_ad", int'(mif.a_adbus), 0);
        chki("rst_b_ad", int'(mif.b_adbus), 0);
        chkw("rst_op_a", mif.mul_op_a, '0);
        chkw("rst_op_b", mif.mul_op_b, '0);
        step();
        rst_n = 1'b1;
        repeat (50) step();
        chki("rst_no_done", n_done, sd);
        chki("rst_no_err", n_err, se);
        send(4, 5, 11, 5, 1'b0);
        wait_quiet();
        chkw("rst_next_ram11", ram[11], ref_mem[11]);

        send(8, 9, 12, 10, 1'b1);
        wait_quiet();
        chkw("spur_ram12", ram[12], ref_mem[12]);

        for (int i = 0; i < 25; i++) begin
            send(rand_addr(), rand_addr(), rand_addr(),
                 int'($urandom_range(1, 25)), $urandom_range(0, 3) == 0);
            wait_quiet();
            repeat ($urandom_range(0, 3)) step();
        end

        for (int i = 0; i < DEPTH; i++) chkw("final_ram", ram[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mul_operand_sequencer.md
Name: mul_operand_sequencer

Overview:
- Command-driven sequencer directly upstream/downstream of the 48x256 dual-port operand RAM.
- Per command: reads two operands through RAM ports A and B, hands them to the field multiplier with a start/done handshake, and writes the product back through port A.
- Serialises all multiplier traffic. One command in flight at a time.

Parameters:
- DATA, 256, operand/result width in bits.
- ADDR, 6, RAM address width.
- DEPTH, 48, number of valid RAM words; addresses >= DEPTH are illegal.
- TIMEOUT, 1024, maximum WAIT cycles before abort; counter width is clog2(TIMEOUT+1).

Ports:
- clk, in, 1, single clock; all logic on posedge.
- rst_n, in, 1, synchronous active-low reset.
- cmd_valid, in, 1, command present.
- cmd_ready, out, 1, sequencer can accept a command.
- cmd_src_a, in, ADDR, first operand address.
- cmd_src_b, in, ADDR, second operand address.
- cmd_dst, in, ADDR, result address.
- a_w, out, 1, RAM port A write enable.
- a_adbus, out, ADDR, RAM port A address.
- a_data_in, out, DATA, RAM port A write data.
- a_data_out, in, DATA, RAM port A read data (1-cycle registered read).
- b_w, out, 1, RAM port B write enable; constant 0.
- b_adbus, out, ADDR, RAM port B address.
- b_data_in, out, DATA, constant 0.
- b_data_out, in, DATA, RAM port B read data.
- mul_start, out, 1, one-cycle multiplier start pulse.
- mul_op_a, out, DATA, multiplier operand A.
- mul_op_b, out, DATA, multiplier operand B.
- mul_done, in, 1, multiplier result valid (single-cycle pulse).
- mul_result, in, DATA, multiplier product.
- done, out, 1, one-cycle pulse when the writeback commits.
- err, out, 1, one-cycle pulse on illegal address or timeout.
- busy, out, 1, high in every state except IDLE.

Behaviour:
- States: IDLE, READ, CAPT, START, WAIT, WRITE, DONE. Encoding lives in the package.
- Outputs are decoded from registered state/data.
- After any clock edge with rst_n=0, every output is 0, state is IDLE, and all internal registers are 0. cmd_ready also reads 0 while rst_n=0.
- IDLE: cmd_ready=1.
  - Accept on cmd_valid&&cmd_ready (cycle T).
  - If any of src_a, src_b or dst is >= DEPTH: err=1 in T+1, stay IDLE, no RAM or multiplier activity.
  - Otherwise latch all three addresses and go to READ.
- READ (T+1): a_adbus=src_a, b_adbus=src_b, a_w=0. The RAM registers its outputs at this edge.
- CAPT (T+2): latch a_data_out into op_a_reg and b_data_out into op_b_reg.
- START (T+3): mul_start=1 for exactly this cycle.
  - mul_op_a/mul_op_b come from the op regs and hold stable from START until leaving WAIT.
  - Clear the timeout counter.
- WAIT (T+4 onward): mul_done is sampled only in this state; a pulse in any other state is ignored.
  - On mul_done: latch mul_result into res_reg and go to WRITE.
  - Otherwise increment the counter. When it reaches TIMEOUT: err=1 next cycle, go to IDLE, no write.
- WRITE: a_w=1, a_adbus=dst, a_data_in=res_reg for exactly one cycle.
- DONE: done=1, then go to IDLE. cmd_ready returns the following cycle.
- Minimum command-to-command spacing: 6 cycles plus multiplier latency.
- src_a==src_b and src==dst are legal. Reads complete before the write, so there is no hazard.
- a_adbus/b_adbus hold their last value outside READ/WRITE. a_data_in is 0 outside WRITE.
- Reset mid-operation aborts the command; no done and no err are produced.
  - If rst_n falls in the WRITE cycle, that write still commits at the edge, because the RAM sees a_w=1 that cycle.
  - From the next cycle a_w=0.
- Port B is read-only from this block; b_w is never asserted.

Decomposition:
- Package mul_seq_pkg holds:
  - state encoding constants;
  - DEFAULT_DEPTH=48 and DEFAULT_TIMEOUT=1024;
  - an address-range check function (addr < DEPTH).
- One sub-module is natural: mul_seq_timeout_ctr, the clear/enable counter with a terminal flag, reused by later sequencers.
- Everything else stays flat in mul_operand_sequencer.

Test Plan:
- Basic op:
  - Stimulus: preload RAM[3]=X, RAM[7]=Y; command (3,7,10); model multiplier returns X*Y mod p after 20 cycles.
  - Required: mul_start exactly at T+3 with mul_op_a=X and mul_op_b=Y; a single a_w at RAM[10]; done the next cycle; RAM[10]=product; cmd_ready back high.
- Back-to-back:
  - Stimulus: cmd_valid held high with two commands, (1,2,5) then (5,5,6).
  - Required: the second command is accepted only after DONE; RAM[6]=(RAM1*RAM2)^2, proving the second read sees the first write.
- Illegal address:
  - Stimulus: command (3,48,10).
  - Required: err pulse at T+1; a_w, mul_start and busy stay 0; cmd_ready stays high.
- Timeout:
  - Stimulus: multiplier never asserts mul_done.
  - Required: err pulses exactly TIMEOUT cycles after WAIT entry; no a_w; state returns to IDLE.
- Reset mid-WAIT:
  - Stimulus: rst_n=0 for 2 cycles during WAIT.
  - Required: after the reset edge, all outputs are 0; no done and no err; a late mul_done is ignored; the next command runs normally.
- Spurious done:
  - Stimulus: mul_done pulsed while the sequencer is in CAPT.
  - Required: the pulse is ignored; the sequencer waits for a real mul_done in WAIT; the writeback value is correct.
